t05_huffman_decoder: RTL and testbench

T05_HUFFMAN_DECODER -- requirements
Module: t05_huffman_decoder

---
 rtl/t05_huffman_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_t05_huffman_decoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t05_huffman_decoder.sv
// Serial Huffman tree-walk decoder: consumes code bits, fetches tree nodes, emits characters.
// Optional macro T05_DEC_ROOT_CACHE_EN keeps the root's children in registers after the first fetch.
module t05_huffman_decoder #(
  parameter logic [3:0] DEC_STATE = 4'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en_state,
  input  logic [8:0]  root,
  input  logic [15:0] char_total,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic        tree_rd_en,
  output logic [7:0]  tree_addr,
  input  logic        tree_rd_valid,
  input  logic [8:0]  tree_left,
  input  logic [8:0]  tree_right,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        fin_state,
  output logic        err,
  output logic [15:0] char_count
);

  localparam logic [8:0] NULL_CODE = 9'h180;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_NODE, WAIT_BIT, EMIT, DONE, ERR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cur_q, cur_d;
  logic [8:0]  left_q, left_d, right_q, right_d;
  logic [7:0]  char_out_q, char_out_d;
  logic [15:0] char_count_q, char_count_d;
  logic        bit_ready_q, bit_ready_d;
  logic        tree_rd_en_q, tree_rd_en_d;
  logic [7:0]  tree_addr_q, tree_addr_d;
  logic        char_valid_q, char_valid_d;
  logic        fin_state_q, fin_state_d;
  logic        err_q, err_d;

`ifdef T05_DEC_ROOT_CACHE_EN
  logic [8:0]  root_left_q, root_left_d, root_right_q, root_right_d;
  logic        cache_valid_q, cache_valid_d;
`endif

  logic        enabled;
  logic        start_root;
  logic        last_char;
  logic [8:0]  child;

  assign enabled   = (en_state == DEC_STATE);
  assign child     = bit_in ? right_q : left_q;
  assign last_char = ({1'b0, char_count_q} + 17'd1) == {1'b0, char_total};

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave one unassigned and infer a latch.
    state_d      = state_q;
    cur_d        = cur_q;
    left_d       = left_q;
    right_d      = right_q;
    char_out_d   = char_out_q;
    char_count_d = char_count_q;
    tree_addr_d  = tree_addr_q;
    start_root   = 1'b0;
`ifdef T05_DEC_ROOT_CACHE_EN
    root_left_d   = root_left_q;
    root_right_d  = root_right_q;
    cache_valid_d = cache_valid_q;
`endif

    case (state_q)
      IDLE: begin
        if (char_total == 16'd0) state_d = DONE;
        else if (root == NULL_CODE) state_d = ERR;
        else start_root = 1'b1;
      end
      FETCH: state_d = WAIT_NODE;
      WAIT_NODE: begin
        if (tree_rd_valid) begin
          left_d  = tree_left;
          right_d = tree_right;
          state_d = WAIT_BIT;
`ifdef T05_DEC_ROOT_CACHE_EN
          // The first fetch after leaving IDLE is always the root.
          if (!cache_valid_q) begin
            root_left_d   = tree_left;
            root_right_d  = tree_right;
            cache_valid_d = 1'b1;
          end
`endif
        end
      end
      WAIT_BIT: begin
        if (bit_valid && bit_ready_q) begin
          if (child == NULL_CODE) state_d = ERR;
          else if (!child[8]) begin
            char_out_d = child[7:0];
            state_d    = EMIT;
          end else begin
            cur_d   = child[7:0];
            state_d = FETCH;
          end
        end
      end
      EMIT: begin
        if (char_ready) begin
          // Saturate rather than wrap; char_count never exceeds char_total in practice.
          if (char_count_q != 16'hFFFF) char_count_d = char_count_q + 16'd1;
          if (last_char) state_d = DONE;
          else start_root = 1'b1;
        end
      end
      DONE, ERR: state_d = state_q;
      default:   state_d = IDLE;
    endcase

    if (start_root) begin
      if (!root[8]) begin
        // A leaf root decodes one character per bit whichever way the bit points.
        left_d  = root;
        right_d = root;
        state_d = WAIT_BIT;
      end else begin
`ifdef T05_DEC_ROOT_CACHE_EN
        if (cache_valid_q) begin
          left_d  = root_left_q;
          right_d = root_right_q;
          state_d = WAIT_BIT;
        end else begin
          cur_d   = root[7:0];
          state_d = FETCH;
        end
`else
        cur_d   = root[7:0];
        state_d = FETCH;
`endif
      end
    end

    if (!enabled) begin
      state_d      = IDLE;
      char_count_d = 16'd0;
      char_out_d   = 8'd0;
      tree_addr_d  = 8'd0;
`ifdef T05_DEC_ROOT_CACHE_EN
      cache_valid_d = 1'b0;
`endif
    end

    if (state_d == FETCH) tree_addr_d = cur_d;
    bit_ready_d  = (state_d == WAIT_BIT);
    tree_rd_en_d = (state_d == FETCH);
    char_valid_d = (state_d == EMIT);
    fin_state_d  = (state_d == DONE);
    err_d        = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= 8'd0;
      left_q       <= 9'd0;
      right_q      <= 9'd0;
      char_out_q   <= 8'd0;
      char_count_q <= 16'd0;
      bit_ready_q  <= 1'b0;
      tree_rd_en_q <= 1'b0;
      tree_addr_q  <= 8'd0;
      char_valid_q <= 1'b0;
      fin_state_q  <= 1'b0;
      err_q        <= 1'b0;
`ifdef T05_DEC_ROOT_CACHE_EN
      root_left_q   <= 9'd0;
      root_right_q  <= 9'd0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      left_q       <= left_d;
      right_q      <= right_d;
      char_out_q   <= char_out_d;
      char_count_q <= char_count_d;
      bit_ready_q  <= bit_ready_d;
      tree_rd_en_q <= tree_rd_en_d;
      tree_addr_q  <= tree_addr_d;
      char_valid_q <= char_valid_d;
      fin_state_q  <= fin_state_d;
      err_q        <= err_d;
`ifdef T05_DEC_ROOT_CACHE_EN
      root_left_q   <= root_left_d;
      root_right_q  <= root_right_d;
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  assign bit_ready  = bit_ready_q;
  assign tree_rd_en = tree_rd_en_q;
  assign tree_addr  = tree_addr_q;
  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;
  assign fin_state  = fin_state_q;
  assign err        = err_q;
  assign char_count = char_count_q;

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Self-checking bench for t05_huffman_decoder: directed scenarios plus randomized trees
// checked against a tree-walking reference model.
module tb_t05_huffman_decoder;

  localparam logic [3:0] DEC = 4'd7;
  localparam logic [8:0] NUL = 9'h180;
`ifdef T05_DEC_ROOT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk, rst;
  logic [3:0]  en_state;
  logic [8:0]  root;
  logic [15:0] char_total;
  logic        bit_in, bit_valid, bit_ready;
  logic        tree_rd_en, tree_rd_valid;
  logic [7:0]  tree_addr;
  logic [8:0]  tree_left, tree_right;
  logic [7:0]  char_out;
  logic        char_valid, char_ready;
  logic        fin_state, err;
  logic [15:0] char_count;

  t05_huffman_decoder #(.DEC_STATE(DEC)) dut (
    .clk(clk), .rst(rst), .en_state(en_state), .root(root), .char_total(char_total),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .tree_rd_en(tree_rd_en), .tree_addr(tree_addr), .tree_rd_valid(tree_rd_valid),
    .tree_left(tree_left), .tree_right(tree_right),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .fin_state(fin_state), .err(err), .char_count(char_count)
  );

  logic [8:0] tl [256];
  logic [8:0] tr [256];
  bit         bits_q[$];
  bit         stim_bits[$];
  logic [7:0] got[$];
  logic [7:0] exp_chars[$];
  int         bits_taken, reads, exp_bits, exp_reads;
  bit         exp_err, exp_fin;
  int         n_cmp = 0, n_bad = 0;
  bit         stall = 0, rdy_rand = 0, bit_gaps = 0;
  int         dly_min = 0, dly_max = 0;
  bit         pending = 0;
  int         pend_cnt = 0;
  logic [7:0] pend_addr = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Environment: records handshakes at the rising edge, drives inputs at the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (bit_valid && bit_ready) begin
        bits_taken++;
        if (bits_q.size() > 0) void'(bits_q.pop_front());
      end
      if (char_valid && char_ready) got.push_back(char_out);
      if (tree_rd_en) begin
        reads++;
        pending   = 1'b1;
        pend_addr = tree_addr;
        pend_cnt  = $urandom_range(dly_max, dly_min);
      end
      @(negedge clk);
      if (bits_q.size() > 0 && (!bit_gaps || $urandom_range(3, 0) != 0)) begin
        bit_valid = 1'b1;
        bit_in    = bits_q[0];
      end else begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(1, 0));
      end
      char_ready = stall ? 1'b0 : (rdy_rand ? ($urandom_range(2, 0) != 0) : 1'b1);
      if (pending) begin
        if (pend_cnt == 0) begin
          tree_rd_valid = 1'b1;
          tree_left     = tl[pend_addr];
          tree_right    = tr[pend_addr];
          pending       = 1'b0;
        end else begin
          pend_cnt--;
          tree_rd_valid = 1'b0;
        end
      end else if ($urandom_range(7, 0) == 0) begin
        tree_rd_valid = 1'b1;
        tree_left     = 9'($urandom);
        tree_right    = 9'($urandom);
      end else begin
        tree_rd_valid = 1'b0;
      end
    end
  end

  // Reference: walk the tree per character from the root using the bit list.
  task automatic ref_model(input logic [8:0] rt, input int total);
    logic [8:0] node, child;
    bit root_seen;
    root_seen = 1'b0;
    exp_chars.delete();
    exp_err = 0; exp_fin = 0; exp_bits = 0; exp_reads = 0;
    if (total == 0) begin exp_fin = 1; return; end
    if (rt == NUL) begin exp_err = 1; return; end
    while (exp_chars.size() < total) begin
      if (exp_bits >= stim_bits.size()) return;
      if (!rt[8]) begin
        exp_chars.push_back(rt[7:0]);
        exp_bits++;
        continue;
      end
      node = rt;
      forever begin
        if (!(CACHE && node == rt && root_seen)) exp_reads++;
        if (node == rt) root_seen = 1'b1;
        if (exp_bits >= stim_bits.size()) return;
        child = stim_bits[exp_bits] ? tr[node[7:0]] : tl[node[7:0]];
        exp_bits++;
        if (child == NUL) begin exp_err = 1; return; end
        if (!child[8]) begin exp_chars.push_back(child[7:0]); break; end
        node = child;
      end
    end
    exp_fin = 1;
  endtask

  task automatic basic_tree();
    tl[0] = 9'h041; tr[0] = 9'h101;
    tl[1] = 9'h042; tr[1] = 9'h043;
  endtask

  task automatic begin_case(input logic [8:0] rt, input int total);
    en_state = 4'd0;
    bits_q.delete();
    repeat (2) @(negedge clk);
    pending    = 1'b0;
    root       = rt;
    char_total = 16'(total);
    bits_q     = stim_bits;
    got.delete();
    bits_taken = 0;
    reads      = 0;
    ref_model(rt, total);
    en_state   = DEC;
  endtask

  task automatic finish_case(input string tag, input int budget);
    int n;
    for (int c = 0; c < budget && !(fin_state || err); c++) @(negedge clk);
    check({tag, ".done_or_err"}, 32'(fin_state || err), 32'd1);
    repeat (4) @(negedge clk);
    check({tag, ".nchar"}, got.size(), exp_chars.size());
    n = (got.size() < exp_chars.size()) ? got.size() : exp_chars.size();
    for (int i = 0; i < n; i++) check({tag, ".char"}, got[i], exp_chars[i]);
    check({tag, ".fin"}, fin_state, exp_fin);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".count"}, char_count, exp_chars.size());
    check({tag, ".bits"}, bits_taken, exp_bits);
    check({tag, ".reads"}, reads, exp_reads);
    check({tag, ".bit_ready"}, bit_ready, 32'd0);
    check({tag, ".char_valid"}, char_valid, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".bit_ready"}, bit_ready, 32'd0);
    check({tag, ".tree_rd_en"}, tree_rd_en, 32'd0);
    check({tag, ".tree_addr"}, tree_addr, 32'd0);
    check({tag, ".char_valid"}, char_valid, 32'd0);
    check({tag, ".char_out"}, char_out, 32'd0);
    check({tag, ".fin"}, fin_state, 32'd0);
    check({tag, ".err"}, err, 32'd0);
    check({tag, ".count"}, char_count, 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    int k, n, total;
    logic [8:0] rt;
    bit seen;

    for (int i = 0; i < 256; i++) begin tl[i] = 9'd0; tr[i] = 9'd0; end
    basic_tree();
    bit_in = 0; bit_valid = 0; tree_rd_valid = 0; tree_left = 0; tree_right = 0; char_ready = 1;
    // Reset asserted while the block is enabled: reset must win.
    rst = 1'b1; en_state = DEC; root = 9'h100; char_total = 16'd3;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0; en_state = 4'd0;
    @(negedge clk);

    // A, B, C from bits 0,1,0,1,1 with first-character latency of one level + EMIT.
    stim_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    begin_case(9'h100, 3);
    repeat (3) @(negedge clk);
    check("abc.lat_before", char_valid, 32'd0);
    @(negedge clk);
    check("abc.lat_valid", char_valid, 32'd1);
    check("abc.lat_char", char_out, 32'h41);
    finish_case("abc", 500);

    // Consumer stall in EMIT.
    stim_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit_gaps = 1; dly_max = 2;
    begin_case(9'h100, 3);
    stall = 1;
    for (int c = 0; c < 200 && !char_valid; c++) @(negedge clk);
    check("stall.valid_seen", char_valid, 32'd1);
    held = char_out;
    n = bits_taken;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall.valid", char_valid, 32'd1);
      check("stall.char", char_out, held);
      check("stall.bit_ready", bit_ready, 32'd0);
      check("stall.bits", bits_taken, n);
    end
    stall = 0;
    finish_case("stall", 500);

    // Null right child of node1.
    tr[1] = NUL;
    stim_bits = '{1'b1, 1'b1, 1'b0, 1'b0};
    begin_case(9'h100, 3);
    finish_case("null", 500);
    repeat (5) @(negedge clk);
    check("null.err_hold", err, 32'd1);
    check("null.bits_hold", bits_taken, 32'd2);
    basic_tree();

    // Leaf root 'Z'.
    stim_bits = '{1'b0, 1'b1, 1'b1};
    begin_case(9'h05A, 2);
    finish_case("leafroot", 500);

    // char_total of zero completes one cycle after enable.
    stim_bits = '{1'b1, 1'b0};
    begin_case(9'h100, 0);
    @(negedge clk);
    check("zero.fin_1cyc", fin_state, 32'd1);
    check("zero.reads", reads, 32'd0);
    check("zero.bits", bits_taken, 32'd0);
    finish_case("zero", 50);

    // Abort in WAIT_NODE, then re-enable from scratch.
    stim_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    dly_min = 6; dly_max = 6;
    begin_case(9'h100, 3);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = pending;
    end
    check("abort.wait_node_seen", 32'(seen), 32'd1);
    en_state = 4'd0;
    pending = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    dly_min = 0; dly_max = 3;
    begin_case(9'h100, 3);
    finish_case("reenable", 500);

    // Randomized trees, stalls and gaps.
    rdy_rand = 1;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 256; i++) begin tl[i] = 9'd0; tr[i] = 9'd0; end
      k = $urandom_range(240, 0);
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) begin
        for (int s = 0; s < 2; s++) begin
          if ($urandom_range(19, 0) == 0) rt = NUL;
          else if (i < n - 1 && $urandom_range(2, 0) != 0)
            rt = {1'b1, 8'(k + $urandom_range(n - 1, i + 1))};
          else rt = {1'b0, 8'($urandom)};
          if (s == 0) tl[k + i] = rt; else tr[k + i] = rt;
        end
      end
      rt = ($urandom_range(7, 0) == 0) ? {1'b0, 8'($urandom)} : {1'b1, 8'(k)};
      total = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(6, 1);
      stim_bits.delete();
      for (int b = 0; b < 64; b++) stim_bits.push_back(1'($urandom_range(1, 0)));
      begin_case(rt, total);
      finish_case("rand", 3000);
    end

    en_state = 4'd0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
